// File: rtl/rom_fetch_ctrl.sv
// Burst read controller for a 512x32 ROM with a small response FIFO and flow control.
// Optional macro ROM_FETCH_CNT_EN adds a saturating 16-bit ROM issue counter (rd_count).
module rom_fetch_ctrl #(
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        scan_mode,
   input  logic        req_valid,
   input  logic [8:0]  req_addr,
   input  logic [2:0]  req_len,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   input  logic        rsp_ready,
   output logic        rom_me,
   output logic [8:0]  rom_adr,
   input  logic [31:0] rom_q,
`ifdef ROM_FETCH_CNT_EN
   output logic        busy,
   output logic [15:0] rd_count
`else
   output logic        busy
`endif
);

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 3;
   localparam int unsigned PW = $clog2(RSP_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [LW-1:0]  rem_q, rem_d;
   logic           inflight_q;
   logic [DW-1:0]  mem_q [RSP_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           req_ready_q;
   logic           busy_q;
   logic           issue;
   logic           push;
   logic           pop;

   // A read may only go out if its word is guaranteed a FIFO slot on landing.
   assign issue = (state_q == S_ISSUE) && !scan_mode &&
                  ((32'(cnt_q) + 32'(inflight_q)) < RSP_DEPTH);
   assign push  = inflight_q;
   assign pop   = rsp_valid && rsp_ready;
   assign cnt_d = cnt_q + CW'(push) - CW'(pop);

   assign rom_me    = issue;
   assign rom_adr   = issue ? addr_q : '0;
   assign rsp_valid = (cnt_q != '0);
   assign rsp_data  = mem_q[rd_ptr_q];
   assign req_ready = req_ready_q;
   assign busy      = busy_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               rem_d   = req_len;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               addr_d = addr_q + AW'(1);
               if (rem_q == '0) begin
                  state_d = S_DRAIN;
               end else begin
                  rem_d = rem_q - LW'(1);
               end
            end
         end
         // The last read lands during this cycle; it is pushed at the closing edge.
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         inflight_q  <= issue;
         cnt_q       <= cnt_d;
         req_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE) || (cnt_d != '0);
         if (push) begin
            mem_q[wr_ptr_q] <= rom_q;
         end
         wr_ptr_q <= wr_ptr_q + PW'(push);
         rd_ptr_q <= rd_ptr_q + PW'(pop);
      end
   end

`ifdef ROM_FETCH_CNT_EN
   logic [15:0] rd_count_q;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         rd_count_q <= '0;
      end else if (issue && (rd_count_q != 16'hFFFF)) begin
         rd_count_q <= rd_count_q + 16'd1;
      end
   end

   assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomised self-checking bench for rom_fetch_ctrl against a queue-based burst/ROM model.
module tb_rom_fetch_ctrl;

   localparam int unsigned DEPTH = 4;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        scan_mode = 1'b0;
   logic        req_valid = 1'b0;
   logic [8:0]  req_addr = '0;
   logic [2:0]  req_len = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_ready = 1'b1;
   logic        rom_me;
   logic [8:0]  rom_adr;
   logic [31:0] rom_q = '0;
   logic        busy;
`ifdef ROM_FETCH_CNT_EN
   logic [15:0] rd_count;
`endif

   rom_fetch_ctrl #(.RSP_DEPTH(DEPTH)) dut (
      .CLK(CLK), .reset_n(reset_n), .scan_mode(scan_mode),
      .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .rom_me(rom_me), .rom_adr(rom_adr), .rom_q(rom_q),
`ifdef ROM_FETCH_CNT_EN
      .busy(busy), .rd_count(rd_count)
`else
      .busy(busy)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // ROM contents and a one-cycle-latency ROM; rom_q is junk when no read was made.
   logic [31:0] rom_mem [512];
   logic        me_s = 1'b0;
   logic [8:0]  adr_s = '0;
   always @(negedge CLK) begin
      me_s  = rom_me;
      adr_s = rom_adr;
   end
   always @(posedge CLK) rom_q <= me_s ? rom_mem[adr_s] : $urandom;

   // Reference model: every accepted burst queues its addresses and its expected words.
   logic [8:0]  exp_adr [$];
   logic [31:0] exp_rsp [$];
   int          issued_total = 0;
   int          popped_total = 0;
   bit          mon_en = 1'b0;
   logic [8:0]  mon_a;
   logic [31:0] mon_d;

   always @(negedge CLK) begin
      if (mon_en && reset_n) begin
         checks++;
         if (busy !== (exp_rsp.size() != 0)) begin
            errors++;
            $display("FAIL busy got %0b exp %0b", busy, exp_rsp.size() != 0);
         end
         if (rom_me === 1'b1) begin
            checks++;
            if (exp_adr.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue got adr %h exp no issue", rom_adr);
            end else begin
               mon_a = exp_adr.pop_front();
               if (rom_adr !== mon_a) begin
                  errors++;
                  $display("FAIL issue_adr got %h exp %h", rom_adr, mon_a);
               end
            end
            checks++;
            if (scan_mode !== 1'b0) begin
               errors++;
               $display("FAIL issue_in_scan got rom_me 1 exp 0");
            end
            checks++;
            if (issued_total - popped_total + 1 > DEPTH) begin
               errors++;
               $display("FAIL overcommit got %0d outstanding exp <= %0d",
                        issued_total - popped_total + 1, DEPTH);
            end
            issued_total++;
         end else begin
            checks++;
            if (rom_adr !== 9'h000) begin
               errors++;
               $display("FAIL idle_adr got %h exp 000", rom_adr);
            end
         end
         if (rsp_valid === 1'b1 && rsp_ready) begin
            checks++;
            if (exp_rsp.size() == 0) begin
               errors++;
               $display("FAIL spurious_rsp got %h exp nothing", rsp_data);
            end else begin
               mon_d = exp_rsp.pop_front();
               if (rsp_data !== mon_d) begin
                  errors++;
                  $display("FAIL rsp_data got %h exp %h", rsp_data, mon_d);
               end
            end
            popped_total++;
         end
         if (req_valid && req_ready === 1'b1) begin
            for (int i = 0; i <= int'(req_len); i++) begin
               mon_a = req_addr + 9'(i);
               exp_adr.push_back(mon_a);
               exp_rsp.push_back(rom_mem[mon_a]);
            end
         end
      end
   end

   bit rand_drv = 1'b0;
   always @(posedge CLK) begin
      if (rand_drv) begin
         #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         scan_mode = ($urandom_range(0, 7) == 0);
      end
   end

   task automatic send(input logic [8:0] a, input logic [2:0] l);
      int n = 0;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_addr = a; req_len = l;
      @(negedge CLK);
      while (req_ready !== 1'b1 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout got req_ready %b exp 1", req_ready);
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((busy !== 1'b0 || exp_rsp.size() != 0) && n < 600);
      checks++;
      if (busy !== 1'b0 || exp_rsp.size() != 0 || exp_adr.size() != 0) begin
         errors++;
         $display("FAIL %s_idle got busy %b pending %0d exp busy 0 pending 0",
                  tag, busy, exp_rsp.size());
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset_n = 1'b0; mon_en = 1'b0;
      exp_adr.delete(); exp_rsp.delete();
      issued_total = 0; popped_total = 0;
      repeat (2) @(negedge CLK);
      reset_n = 1'b1; mon_en = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rom_me, rom_adr, rsp_valid, rsp_data, busy, req_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got me %b adr %h rv %b rd %h busy %b rr %b exp all 0",
                  rom_me, rom_adr, rsp_valid, rsp_data, busy, req_ready);
      end
`ifdef ROM_FETCH_CNT_EN
      checks++;
      if (rd_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_rd_count got %0d exp 0", rd_count);
      end
`endif
      @(negedge CLK);
      reset_n = 1'b1; mon_en = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge got %b exp 0", req_ready);
      end
      @(posedge CLK); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_edge got %b exp 1", req_ready);
      end
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_addr = 9'h010; req_len = 3'd0;
      @(negedge CLK);
      checks++;
      if (req_ready !== 1'b1 || rom_me !== 1'b0) begin
         errors++;
         $display("FAIL single_accept got rr %b me %b exp 1 0", req_ready, rom_me);
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (rom_me !== 1'b1 || rom_adr !== 9'h010) begin
         errors++;
         $display("FAIL single_issue got me %b adr %h exp 1 010", rom_me, rom_adr);
      end
      @(negedge CLK);
      checks++;
      if (rom_me !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_gap got me %b rv %b exp 0 0", rom_me, rsp_valid);
      end
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== rom_mem[16]) begin
         errors++;
         $display("FAIL single_data got rv %b %h exp 1 %h", rsp_valid, rsp_data, rom_mem[16]);
      end
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b0 || rom_me !== 1'b0) begin
         errors++;
         $display("FAIL single_after got rv %b me %b exp 0 0", rsp_valid, rom_me);
      end
      wait_idle("single");
   endtask

   task automatic test_wrap();
      int p0 = popped_total;
      rsp_ready = 1'b1;
      send(9'h1FE, 3'd3);
      wait_idle("wrap");
      checks++;
      if (popped_total - p0 != 4) begin
         errors++;
         $display("FAIL wrap_count got %0d exp 4", popped_total - p0);
      end
   endtask

   task automatic test_backpressure();
      int k = 0;
      int p0 = popped_total;
      rsp_ready = 1'b0;
      send(9'h0A0, 3'd7);
      repeat (20) begin
         @(negedge CLK);
         if (rom_me === 1'b1) k++;
      end
      checks++;
      if (k != DEPTH || rom_me !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_issues got %0d me %b rv %b exp %0d 0 1", k, rom_me, rsp_valid, DEPTH);
      end
      @(posedge CLK); #1;
      rsp_ready = 1'b1;
      wait_idle("bp");
      checks++;
      if (popped_total - p0 != 8) begin
         errors++;
         $display("FAIL bp_count got %0d exp 8", popped_total - p0);
      end
   endtask

   task automatic test_scan();
      int k = 0;
      int p0 = popped_total;
      rsp_ready = 1'b1;
      send(9'h133, 3'd7);
      @(posedge CLK); #1;
      scan_mode = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         if (rom_me !== 1'b0) k++;
      end
      @(posedge CLK); #1;
      scan_mode = 1'b0;
      checks++;
      if (k != 0) begin
         errors++;
         $display("FAIL scan_freeze got %0d issues exp 0", k);
      end
      wait_idle("scan");
      checks++;
      if (popped_total - p0 != 8) begin
         errors++;
         $display("FAIL scan_count got %0d exp 8", popped_total - p0);
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int n = 0;
      rsp_ready = 1'b0;
      send(9'h100, 3'd7);
      while (k < 3 && n < 50) begin
         @(negedge CLK);
         if (rom_me === 1'b1) k++;
         n++;
      end
      checks++;
      if (k != 3) begin
         errors++;
         $display("FAIL rmid_issues got %0d exp 3", k);
      end
      reset_n = 1'b0; mon_en = 1'b0;
      exp_adr.delete(); exp_rsp.delete();
      issued_total = 0; popped_total = 0;
      #1;
      checks++;
      if ({rom_me, rom_adr, rsp_valid, rsp_data, busy, req_ready} !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got me %b adr %h rv %b rd %h busy %b rr %b exp all 0",
                  rom_me, rom_adr, rsp_valid, rsp_data, busy, req_ready);
      end
      repeat (2) @(negedge CLK);
      reset_n = 1'b1; mon_en = 1'b1;
      rsp_ready = 1'b1;
      send(9'h020, 3'd0);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== rom_mem[32]) begin
         errors++;
         $display("FAIL rmid_first got rv %b %h exp 1 %h", rsp_valid, rsp_data, rom_mem[32]);
      end
      wait_idle("rmid");
   endtask

   task automatic test_back_to_back();
      rand_drv = 1'b1;
      for (int b = 0; b < 30; b++) begin
         send(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)));
      end
      rand_drv = 1'b0;
      @(posedge CLK); #2;
      rsp_ready = 1'b1; scan_mode = 1'b0;
      wait_idle("b2b");
   endtask

`ifdef ROM_FETCH_CNT_EN
   task automatic test_counter();
      do_reset();
      rsp_ready = 1'b1;
      send(9'h040, 3'd0); wait_idle("cnt1");
      send(9'h050, 3'd3); wait_idle("cnt4");
      send(9'h1FC, 3'd7); wait_idle("cnt8");
      checks++;
      if (rd_count !== 16'd13) begin
         errors++;
         $display("FAIL rd_count got %0d exp 13", rd_count);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 512; i++) rom_mem[i] = $urandom;
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_scan();
      test_reset_mid();
      test_back_to_back();
      do_reset();
      test_wrap();
`ifdef ROM_FETCH_CNT_EN
      test_counter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 4: response FIFO depth in words; power of two, 2..8.
REQ-002 SHALL have port CLK, input, 1: single clock; all flops rise on CLK.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port scan_mode, input, 1: test mode; inhibits ROM access.
REQ-005 SHALL have port req_valid, input, 1: burst request present.
REQ-006 SHALL have port req_addr, input, 9: burst start word address.
REQ-007 SHALL have port req_len, input, 3: burst length minus one (1..8 words).
REQ-008 SHALL have port req_ready, output, 1: request accepted this cycle when high with req_valid.
REQ-009 SHALL have port rsp_valid, output, 1: rsp_data holds a valid word.
REQ-010 SHALL have port rsp_data, output, 32: read word, in address order.
REQ-011 SHALL have port rsp_ready, input, 1: consumer takes word when high with rsp_valid.
REQ-012 SHALL have port rom_me, output, 1: ROM enable to the 512x32 ROM wrapper.
REQ-013 SHALL have port rom_adr, output, 9: ROM word address.
REQ-014 SHALL have port rom_q, input, 32: ROM data, valid one cycle after rom_me high.
REQ-015 SHALL have port busy, output, 1: burst in progress or FIFO non-empty.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, DRAIN.
- IDLE: req_ready=1; on req_valid, latch addr/len, go to ISSUE.
- ISSUE: req_ready=0; issue reads; after last issue, go to DRAIN.
- DRAIN: wait for the last read to land; go to IDLE the cycle after.
REQ-017 SHALL issue a read (rom_me=1, rom_adr=current address) in ISSUE only when FIFO count plus in-flight reads < RSP_DEPTH and scan_mode=0; otherwise rom_me=0.
REQ-018 SHALL increment the address mod 512 after each issue: 511 wraps to 0.
REQ-019 SHALL write rom_q into the FIFO exactly one cycle after each issue; no ROM data is dropped.
REQ-020 SHALL drive rsp_valid = FIFO non-empty; rsp_data = FIFO head; pop on rsp_valid & rsp_ready.
REQ-021 SHALL handle a simultaneous FIFO push and pop with the count unchanged, including at full and at empty.
- Empty FIFO: rsp_valid falls no earlier than the cycle after the pop.
- Zero-latency bypass is not required.
REQ-022 SHALL accept a new request only in IDLE; the FIFO may still hold words of the previous burst, delivered first.
REQ-023 SHALL freeze issuing while scan_mode=1.
- In-flight read still lands.
- Issuing resumes at the held address when scan_mode returns to 0.
REQ-024 SHALL keep busy high from request acceptance until FSM is IDLE and FIFO is empty.
REQ-025 SHALL drive rom_me=0 and rom_adr=0 whenever no read is issued.

Reset
REQ-026 SHALL on reset_n low set asynchronously:
- FSM to IDLE; FIFO and in-flight flag cleared; address 0.
- rom_me=0, rom_adr=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=0.
REQ-027 SHALL drive req_ready=1 from the first CLK edge after reset_n deasserts.
REQ-028 SHALL on reset mid-burst discard all pending words; no partial burst resumes.

Configuration
REQ-029 SHALL, with macro ROM_FETCH_CNT_EN defined, add output rd_count, 16 bits.
- Counts ROM issues; saturates at 0xFFFF.
- Reset value 0.
REQ-030 SHALL, without ROM_FETCH_CNT_EN, have no rd_count port and no counter logic.

Verification
REQ-031 SHALL verify single word: addr 0x010, len 0, rsp_ready=1 -> one rom_me pulse at 0x010; rsp_data=ROM[0x010] two cycles after acceptance.
REQ-032 SHALL verify wrap: addr 0x1FE, len 3 -> rom_adr 0x1FE, 0x1FF, 0x000, 0x001; four words in that order.
REQ-033 SHALL verify backpressure: len 7, rsp_ready=0 -> exactly RSP_DEPTH (4) issues, then rom_me=0.
- Then release rsp_ready -> all 8 words delivered in order, none lost or duplicated.
REQ-034 SHALL verify scan freeze: scan_mode=1 for 5 cycles mid-burst -> rom_me=0 throughout; burst completes with correct data after.
REQ-035 SHALL verify reset mid-burst: reset_n low after 3 issues -> all outputs at reset values; next burst at 0x020 returns ROM[0x020] first.
REQ-036 SHALL verify counter (ROM_FETCH_CNT_EN): three bursts of lengths 1, 4, 8 -> rd_count=13.
